// File: rtl/agg_acc.sv
`default_nettype none
// ============================================================================
// Module      : agg_acc
// Description : Multi-channel signed packet accumulator. Beats are summed per
//               channel with saturation; on the last beat the result is held
//               with sign/activation/saturation flags and a beat count until
//               the downstream consumer accepts it.
//               Optional build macro AGG_ACC_RELU_EN: when defined, out_data
//               applies a ReLU (negative accumulators read as zero).
// Revision    : 1.0 - initial release
// ============================================================================
module agg_acc #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 16,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*ACC_W-1:0]    out_data,
  output logic [NUM_CH-1:0]          out_sign,
  output logic [NUM_CH-1:0]          out_act,
  output logic [NUM_CH-1:0]          out_sat,
  output logic [CNT_W-1:0]           out_cnt
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        c_cnt_max = '1;
  localparam logic [CNT_W-1:0]        c_cnt_one = CNT_W'(1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_first;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  // A beat is taken only while collecting; HOLD deasserts in_ready so the
  // release cycle can never double as an accept cycle.
  assign w_accept  = in_valid & r_in_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_cnt   = r_cnt;

  // Control FSM: handshake flags, first-beat tracking and saturating beat count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACC;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_first     <= 1'b1;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (in_valid) begin
            // The beat after a last beat always starts a new packet.
            r_first <= in_last;
            if (r_first) begin
              r_cnt <= c_cnt_one;
            end else if (r_cnt != c_cnt_max) begin
              r_cnt <= r_cnt + c_cnt_one;
            end
            if (in_last) begin
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_ACC;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_ACC;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      logic signed [DATA_W-1:0] w_in;
      logic signed [ACC_W-1:0]  w_sext;
      logic signed [ACC_W:0]    w_sum;
      logic                     w_ovf;
      logic signed [ACC_W-1:0]  w_clamped;
      logic signed [ACC_W-1:0]  r_acc;
      logic                     r_sat;

      assign w_in   = in_data[k*DATA_W +: DATA_W];
      assign w_sext = ACC_W'(w_in);
      // One guard bit is enough: the sum of two ACC_W-bit values fits ACC_W+1.
      assign w_sum  = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_sext);
      assign w_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
      assign w_clamped = w_ovf ? (w_sum[ACC_W] ? c_acc_min : c_acc_max)
                               : w_sum[ACC_W-1:0];

      // Per-channel accumulator with sticky clamp flag, restarted on a first beat
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc <= '0;
          r_sat <= 1'b0;
        end else if (w_accept) begin
          if (r_first) begin
            r_acc <= w_sext;
            r_sat <= 1'b0;
          end else begin
            r_acc <= w_clamped;
            r_sat <= r_sat | w_ovf;
          end
        end
      end

      assign out_sign[k] = r_acc[ACC_W-1];
      assign out_act[k]  = ~r_acc[ACC_W-1];
      assign out_sat[k]  = r_sat;
`ifdef AGG_ACC_RELU_EN
      assign out_data[k*ACC_W +: ACC_W] = r_acc[ACC_W-1] ? '0 : r_acc;
`else
      assign out_data[k*ACC_W +: ACC_W] = r_acc;
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_agg_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_agg_acc
// Description : Self-checking bench for agg_acc (DATA_W=12, ACC_W=16,
//               NUM_CH=4, CNT_W=8) with an integer reference model.
//               Honours AGG_ACC_RELU_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_agg_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_sign;
  logic [3:0]  out_act;
  logic [3:0]  out_sat;
  logic [7:0]  out_cnt;

  int checks = 0;
  int passes = 0;

  // reference model state
  int       m_acc [4];
  logic [3:0] m_sat;
  int       m_cnt;
  logic     m_first;
  logic     m_hold;

  agg_acc #(.DATA_W(12), .ACC_W(16), .NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sign(out_sign), .out_act(out_act), .out_sat(out_sat), .out_cnt(out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m_acc[k] = 0;
    m_sat = 4'b0; m_cnt = 0; m_first = 1'b1; m_hold = 1'b0;
  endfunction

  function automatic void model_accept(logic [47:0] d, logic l);
    logic signed [11:0] s;
    int x, t;
    for (int k = 0; k < 4; k++) begin
      s = d[k*12 +: 12];
      x = s;
      if (m_first) begin
        m_acc[k] = x;
        m_sat[k] = 1'b0;
      end else begin
        t = m_acc[k] + x;
        if (t > 32767) begin t = 32767; m_sat[k] = 1'b1; end
        else if (t < -32768) begin t = -32768; m_sat[k] = 1'b1; end
        m_acc[k] = t;
      end
    end
    if (m_first) m_cnt = 1;
    else if (m_cnt < 255) m_cnt = m_cnt + 1;
    m_first = l;
    if (l) m_hold = 1'b1;
  endfunction

  function automatic logic [63:0] exp_data();
    logic [63:0] r;
    int v;
    for (int k = 0; k < 4; k++) begin
      v = m_acc[k];
`ifdef AGG_ACC_RELU_EN
      if (v < 0) v = 0;
`endif
      r[k*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_sign();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (m_acc[k] < 0);
    return r;
  endfunction

  function automatic logic [47:0] pack(int a, int b, int c, int d);
    logic [47:0] r;
    int v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int k = 0; k < 4; k++) r[k*12 +: 12] = v[k][11:0];
    return r;
  endfunction

  // One clock: inputs are sampled as driven, model advances at the edge,
  // and control returns at the following falling edge for checking.
  task automatic tick();
    logic v, l, r;
    logic [47:0] d;
    v = in_valid; l = in_last; r = out_ready; d = in_data;
    @(posedge clk);
    if (rst) model_reset();
    else if (!m_hold) begin
      if (v) model_accept(d, l);
    end else if (r) m_hold = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [47:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (out_data !== 64'h0) $display("FAIL rst_data: got %h expected 0", out_data); else passes++;
    checks++; if (out_act !== 4'hF || out_sign !== 4'h0) $display("FAIL rst_act_sign: got %h/%h expected f/0", out_act, out_sign); else passes++;
    checks++; if (out_sat !== 4'h0 || out_cnt !== 8'h0) $display("FAIL rst_sat_cnt: got %h/%h expected 0/0", out_sat, out_cnt); else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    send(pack(100, 0, 0, 0), 1'b0);
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", out_valid); else passes++;
    send(pack(200, 0, 0, 0), 1'b0);
    send(pack(-50, 0, 0, 0), 1'b1);
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data[15:0] !== 16'd250) $display("FAIL basic_ch0: got %0d expected 250", out_data[15:0]); else passes++;
    checks++; if (out_sign[0] !== 1'b0 || out_act[0] !== 1'b1) $display("FAIL basic_flags: got sign %b act %b expected 0/1", out_sign[0], out_act[0]); else passes++;
    checks++; if (out_cnt !== 8'd3) $display("FAIL basic_cnt: got %0d expected 3", out_cnt); else passes++;
    checks++; if (out_data !== exp_data()) $display("FAIL basic_data: got %h expected %h", out_data, exp_data()); else passes++;
    release_hold();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_release: got valid %b ready %b expected 0/1", out_valid, in_ready); else passes++;
  endtask

  task automatic test_negative();
    logic [15:0] want;
`ifdef AGG_ACC_RELU_EN
    want = 16'h0000;
`else
    want = 16'hF418;
`endif
    send(pack(0, -2048, 0, 0), 1'b0);
    send(pack(0, -1000, 0, 0), 1'b1);
    checks++; if (out_data[31:16] !== want) $display("FAIL neg_ch1: got %h expected %h", out_data[31:16], want); else passes++;
    checks++; if (out_sign[1] !== 1'b1 || out_act[1] !== 1'b0) $display("FAIL neg_flags: got sign %b act %b expected 1/0", out_sign[1], out_act[1]); else passes++;
    checks++; if (out_sign !== exp_sign()) $display("FAIL neg_sign: got %h expected %h", out_sign, exp_sign()); else passes++;
    release_hold();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) send(pack(0, 0, 2047, 0), (i == 19));
    checks++; if (out_data[47:32] !== 16'h7FFF) $display("FAIL sat_ch2: got %h expected 7fff", out_data[47:32]); else passes++;
    checks++; if (out_sat !== 4'b0100) $display("FAIL sat_flags: got %b expected 0100", out_sat); else passes++;
    checks++; if (out_cnt !== 8'd20) $display("FAIL sat_cnt: got %0d expected 20", out_cnt); else passes++;
    release_hold();
    // negative clamp on channel 3
    for (int i = 0; i < 17; i++) send(pack(0, 0, 0, -2048), (i == 16));
    checks++; if (out_data !== exp_data() || out_sat !== 4'b1000) $display("FAIL sat_neg: got %h/%b expected %h/1000", out_data, out_sat, exp_data()); else passes++;
    release_hold();
  endtask

  task automatic test_hold_stall();
    send(pack(-300, 40, 1000, -7), 1'b0);
    send(pack(20, -41, 5, 7), 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 48'($urandom()); in_last = 1'($urandom_range(0, 1)); out_ready = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL stall_hs: got ready %b valid %b expected 0/1", in_ready, out_valid); else passes++;
      checks++; if (out_data !== exp_data() || out_cnt !== 8'd2) $display("FAIL stall_stable: got %h cnt %0d expected %h cnt 2", out_data, out_cnt, exp_data()); else passes++;
    end
    in_data = pack(1, 1, 1, 1); in_last = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_release: got valid %b ready %b expected 0/1", out_valid, in_ready); else passes++;
    send(pack(5, -3, 0, 1), 1'b1);
    checks++; if (out_data[15:0] !== 16'd5 || out_cnt !== 8'd1) $display("FAIL stall_fresh: got ch0 %0d cnt %0d expected 5/1", out_data[15:0], out_cnt); else passes++;
    checks++; if (out_data !== exp_data()) $display("FAIL stall_fresh_data: got %h expected %h", out_data, exp_data()); else passes++;
    release_hold();
  endtask

  task automatic test_reset_midpacket();
    send(pack(1, 2, 3, 4), 1'b0);
    send(pack(1, 2, 3, 4), 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mid_rst_hs: got valid %b ready %b expected 0/1", out_valid, in_ready); else passes++;
    checks++; if (out_data !== 64'h0 || out_cnt !== 8'h0 || out_act !== 4'hF) $display("FAIL mid_rst_vals: got %h cnt %0d act %h expected 0/0/f", out_data, out_cnt, out_act); else passes++;
    @(negedge clk);
    rst = 1'b0;
    send(pack(7, 0, 0, 0), 1'b1);
    checks++; if (out_data[15:0] !== 16'd7 || out_cnt !== 8'd1 || out_valid !== 1'b1) $display("FAIL mid_after: got ch0 %0d cnt %0d valid %b expected 7/1/1", out_data[15:0], out_cnt, out_valid); else passes++;
    // reset while holding a result discards it
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 64'h0 || out_sat !== 4'h0) $display("FAIL hold_rst: got valid %b data %h sat %h expected 0/0/0", out_valid, out_data, out_sat); else passes++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cnt_saturate();
    for (int i = 0; i < 300; i++) send(48'h0, (i == 299));
    checks++; if (out_cnt !== 8'd255) $display("FAIL cnt_sat: got %0d expected 255", out_cnt); else passes++;
    checks++; if (out_sat !== 4'h0 || out_data !== 64'h0) $display("FAIL cnt_sat_flags: got sat %h data %h expected 0/0", out_sat, out_data); else passes++;
    release_hold();
  endtask

  task automatic test_random();
    int beats_left;
    logic [63:0] r;
    beats_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (beats_left == 0) beats_left = $urandom_range(1, 40);
      r = {$urandom(), $urandom()};
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = r[47:0];
      in_last   = (beats_left == 1);
      out_ready = ($urandom_range(0, 2) == 0);
      if (in_valid && !m_hold) beats_left--;
      tick();
      checks++; if (out_valid !== m_hold || in_ready !== !m_hold) $display("FAIL rnd_hs cyc %0d: got valid %b ready %b expected %b/%b", cyc, out_valid, in_ready, m_hold, !m_hold); else passes++;
      checks++; if (out_data !== exp_data()) $display("FAIL rnd_data cyc %0d: got %h expected %h", cyc, out_data, exp_data()); else passes++;
      checks++; if (out_sat !== m_sat || out_cnt !== m_cnt[7:0]) $display("FAIL rnd_sat_cnt cyc %0d: got %h/%0d expected %h/%0d", cyc, out_sat, out_cnt, m_sat, m_cnt); else passes++;
      checks++; if (out_sign !== exp_sign() || out_act !== ~exp_sign()) $display("FAIL rnd_flags cyc %0d: got %h/%h expected %h/%h", cyc, out_sign, out_act, exp_sign(), ~exp_sign()); else passes++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_hold();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_hold_stall();
    test_reset_midpacket();
    test_cnt_saturate();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/agg_acc.md
AGG_ACC -- requirements
Module: agg_acc

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 12, signed per-channel input width.
REQ-002 The block SHALL expose parameter ACC_W, default 16, signed per-channel accumulator width; ACC_W >= DATA_W.
REQ-003 The block SHALL expose parameter NUM_CH, default 4, number of parallel channels.
REQ-004 The block SHALL expose parameter CNT_W, default 8, beat-counter width.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block can accept a beat.
REQ-009 in_data  input  NUM_CH*DATA_W  signed two's-complement operands; channel k in bits [k*DATA_W +: DATA_W].
REQ-010 in_last  input  1  final beat of the current packet.
REQ-011 out_valid  output  1  result held and valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_data  output  NUM_CH*ACC_W  per-channel result; channel k in bits [k*ACC_W +: ACC_W].
REQ-014 out_sign  output  NUM_CH  MSB of each pre-activation sum.
REQ-015 out_act  output  NUM_CH  per-channel activation flag, equal to ~out_sign.
REQ-016 out_sat  output  NUM_CH  per-channel sticky saturation flag for the packet.
REQ-017 out_cnt  output  CNT_W  number of beats accepted in the packet; saturates at 2^CNT_W-1.

Function
REQ-018 The FSM SHALL have exactly two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-019 A beat SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-020 On the first accepted beat of a packet, acc[k] SHALL load sext(in_data[k]) and cnt SHALL load 1; on each later beat, acc[k] SHALL load sat(acc[k]+sext(in_data[k])) and cnt SHALL increment, saturating.
REQ-021 sat() SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; each clamp event SHALL set the channel's sat flag for the rest of the packet.
REQ-022 An accepted beat with in_last=1 SHALL move the FSM ACC->HOLD, so out_valid rises the cycle after that beat (latency 1).
REQ-023 In HOLD, out_data, out_sign, out_act, out_sat and out_cnt SHALL remain stable until out_ready=1.
REQ-024 HOLD with out_ready=1 SHALL return the FSM to ACC on the next edge, and the next accepted beat SHALL be treated as a first beat.
REQ-025 in_ready SHALL be 0 throughout HOLD, so no beat is accepted on the release cycle (no bypass).
REQ-026 A single-beat packet (in_last on the first beat) SHALL produce acc[k] = sext(in_data[k]) and cnt = 1.
REQ-027 out_sign[k] SHALL be acc[k][ACC_W-1] in every state.
REQ-028 Beats with in_valid=0 SHALL leave all state unchanged.

Reset
REQ-029 rst=1 SHALL asynchronously force the FSM to ACC, acc[k]=0, sat=0, cnt=0 and the first-beat flag to 1.
REQ-030 During and after reset, outputs SHALL read out_valid=0, in_ready=1, out_data=0, out_sign=0, out_act=all ones, out_sat=0, out_cnt=0.
REQ-031 A reset asserted mid-packet or in HOLD SHALL discard the partial or held result with no output handshake.

Configuration
REQ-032 Macro AGG_ACC_RELU_EN defined: out_data[k] SHALL be 0 when acc[k] < 0, and acc[k] otherwise.
REQ-033 Macro AGG_ACC_RELU_EN undefined: out_data[k] SHALL equal acc[k] unmodified. out_sign and out_act SHALL be identical in both builds.

Verification (DATA_W=12, ACC_W=16, NUM_CH=4, CNT_W=8)
REQ-034 Reset, then 3 beats ch0 = 100, 200, -50 with last on the third -> one cycle later out_valid=1, ch0=250, out_sign[0]=0, out_act[0]=1, out_cnt=3.
REQ-035 2 beats ch1 = -2048, -1000 -> acc=-3048, out_sign[1]=1; out_data ch1 = 0 with RELU_EN, 0xF418 without.
REQ-036 20 beats ch2 = 2047 -> ch2 = 32767, out_sat[2]=1, other channels' out_sat=0.
REQ-037 HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable; then out_ready=1 -> ACC next cycle, next packet starts from a fresh accumulator.
REQ-038 Assert rst after 2 of 4 beats -> all outputs return to reset values immediately; a following 1-beat packet of 7 -> ch0 = 7, out_cnt=1.
REQ-039 300 beats of 0 -> out_cnt=255, out_sat=0.
